// File: rtl/mbist_mem_if.sv
// ---------------------------------------------------------------------------
// mbist_mem_if
// Connects the MBIST March controller to the buffer test port and the
// background (pattern) generator.
//   pattern_sel  background index driven by the controller
//   MBIST_data   background word D, combinational on pattern_sel
//   mem_addr     buffer address
//   mem_wr_en    write strobe
//   mem_rd_en    read strobe; mem_rdata is valid on the following cycle
//   mem_wdata    write data
//   mem_rdata    read data
// The master modport is the controller; the slave modport is the
// memory/generator side.
// ---------------------------------------------------------------------------
interface mbist_mem_if #(
    parameter int DATA_WIDTH = 19,
    parameter int ADDR_WIDTH = 3,
    parameter int PAT_WIDTH  = 3
);
    logic [PAT_WIDTH-1:0]  pattern_sel;
    logic [DATA_WIDTH-1:0] MBIST_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output pattern_sel, mem_addr, mem_wr_en, mem_rd_en, mem_wdata,
        input  MBIST_data, mem_rdata
    );

    modport slave (
        input  pattern_sel, mem_addr, mem_wr_en, mem_rd_en, mem_wdata,
        output MBIST_data, mem_rdata
    );
endinterface

// File: rtl/mbist_march_controller.sv
// ---------------------------------------------------------------------------
// mbist_march_controller
// Runs a March C- test over one partial-sum buffer for every data
// background of the pattern generator. Background D acts as "0" and ~D
// acts as "1".
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          level, sampled only in IDLE
//   abort          synchronous return to IDLE from any state
//   mem_bus        buffer test port and background generator (master side)
//   busy           high in RUN and DRAIN
//   done           one-cycle pulse at test end
//   fail           sticky mismatch flag, cleared at the next start
//   fail_addr/fail_pattern/fail_element   first-mismatch diagnostics
//   err_count      mismatch count, saturating at 255
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one memory operation per cycle
// DRAIN | compare of the final read
// DONE  | done pulse
// ---------------------------------------------------------------------------
module mbist_march_controller #(
    parameter int SYSTOLIC_SIZE       = 8,
    parameter int WEIGHT_WIDTH        = 8,
    parameter int ACTIVATION_WIDTH    = 8,
    parameter int PARTIAL_SUM_WIDTH   = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
    parameter int ADDR_WIDTH          = $clog2(SYSTOLIC_SIZE),
    parameter int MBIST_PATTERN_DEPTH = 8,
    parameter int PAT_WIDTH           = $clog2(MBIST_PATTERN_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    mbist_mem_if.master           mem_bus,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [PAT_WIDTH-1:0]  fail_pattern,
    output logic [2:0]            fail_element,
    output logic [7:0]            err_count
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
    localparam logic [PAT_WIDTH-1:0]  PAT_MAX  = PAT_WIDTH'(MBIST_PATTERN_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;

    logic [PAT_WIDTH-1:0]         pat_q;
    logic [2:0]                   elem_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic                         phase_q;   // 0: read half of a pair, 1: write half

    logic                         cmp_valid_q;
    logic [PARTIAL_SUM_WIDTH-1:0] cmp_exp_q;
    logic [ADDR_WIDTH-1:0]        cmp_addr_q;
    logic [2:0]                   cmp_elem_q;
    logic [PAT_WIDTH-1:0]         cmp_pat_q;

    // Element decode. E1..E4 are read/write pairs, E0 is write-only and
    // E5 is read-only; E3 and E4 walk the addresses downwards.
    logic                         elem_pair, elem_down, op_rd, step_end, elem_end, last_op;
    logic [ADDR_WIDTH-1:0]        addr_term;
    logic [PARTIAL_SUM_WIDTH-1:0] wr_val, rd_exp;
    logic                         mismatch;

    always_comb begin
        elem_pair = (elem_q != 3'd0) && (elem_q != 3'd5);
        elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
        op_rd     = (elem_q == 3'd5) || (elem_pair && !phase_q);
        step_end  = !elem_pair || phase_q;
        addr_term = elem_down ? '0 : ADDR_MAX;
        elem_end  = step_end && (addr_q == addr_term);
        last_op   = elem_end && (elem_q == 3'd5) && (pat_q == PAT_MAX);
        // Writes of "1" happen in E1/E3, reads of "1" in E2/E4.
        wr_val    = elem_q[0] ? ~mem_bus.MBIST_data : mem_bus.MBIST_data;
        rd_exp    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~mem_bus.MBIST_data
                                                           : mem_bus.MBIST_data;
        mismatch  = cmp_valid_q && (mem_bus.mem_rdata != cmp_exp_q);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_RUN;
                S_RUN:   if (last_op) state_nxt = S_DRAIN;
                S_DRAIN: state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy              = (state == S_RUN) || (state == S_DRAIN);
        done              = (state == S_DONE);
        mem_bus.mem_addr  = '0;
        mem_bus.mem_wr_en = 1'b0;
        mem_bus.mem_rd_en = 1'b0;
        mem_bus.mem_wdata = '0;
        if (state == S_RUN) begin
            mem_bus.mem_addr  = addr_q;
            mem_bus.mem_rd_en = op_rd;
            mem_bus.mem_wr_en = !op_rd;
            mem_bus.mem_wdata = op_rd ? '0 : wr_val;
        end
    end

    assign mem_bus.pattern_sel = pat_q;

    // Background / element / address sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= '0;
            elem_q  <= '0;
            addr_q  <= '0;
            phase_q <= 1'b0;
        end else if (abort || state != S_RUN) begin
            pat_q   <= '0;
            elem_q  <= '0;
            addr_q  <= '0;
            phase_q <= 1'b0;
        end else if (!step_end) begin
            phase_q <= 1'b1;
        end else begin
            phase_q <= 1'b0;
            if (elem_end) begin
                // E3 and E4 start at the top address; all other elements at 0.
                addr_q <= ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
                if (elem_q == 3'd5) begin
                    elem_q <= 3'd0;
                    pat_q  <= pat_q + 1'b1;
                end else begin
                    elem_q <= elem_q + 3'd1;
                end
            end else begin
                addr_q <= elem_down ? addr_q - 1'b1 : addr_q + 1'b1;
            end
        end
    end

    // Read-compare pipeline and failure capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid_q  <= 1'b0;
            cmp_exp_q    <= '0;
            cmp_addr_q   <= '0;
            cmp_elem_q   <= '0;
            cmp_pat_q    <= '0;
            fail         <= 1'b0;
            fail_addr    <= '0;
            fail_pattern <= '0;
            fail_element <= '0;
            err_count    <= '0;
        end else if (abort) begin
            cmp_valid_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            cmp_valid_q  <= 1'b0;
            fail         <= 1'b0;
            fail_addr    <= '0;
            fail_pattern <= '0;
            fail_element <= '0;
            err_count    <= '0;
        end else begin
            if (mismatch) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                if (!fail) begin
                    fail         <= 1'b1;
                    fail_addr    <= cmp_addr_q;
                    fail_pattern <= cmp_pat_q;
                    fail_element <= cmp_elem_q;
                end
            end
            cmp_valid_q <= (state == S_RUN) && op_rd;
            if (state == S_RUN && op_rd) begin
                cmp_exp_q  <= rd_exp;
                cmp_addr_q <= addr_q;
                cmp_elem_q <= elem_q;
                cmp_pat_q  <= pat_q;
            end
        end
    end

endmodule

// File: tb/tb_mbist_march_controller.sv
// ---------------------------------------------------------------------------
// tb_mbist_march_controller
// Directed bench: buffer model with selectable faults (none, stuck-at-1 on
// bit 0 of addr 5, addr 3 aliased onto addr 2) and an 8-entry background
// table. Expected values are worked out by hand from the March C- sequence.
// ---------------------------------------------------------------------------
module tb_mbist_march_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, fail;
    logic [2:0] fail_addr, fail_pattern, fail_element;
    logic [7:0] err_count;

    int n_assert = 0;
    int n_fail   = 0;
    int fault_mode = 0;

    logic [18:0] mem [8];

    always #5 clk = ~clk;

    mbist_mem_if #(.DATA_WIDTH(19), .ADDR_WIDTH(3), .PAT_WIDTH(3)) bus ();

    mbist_march_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .mem_bus      (bus.master),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .fail_addr    (fail_addr),
        .fail_pattern (fail_pattern),
        .fail_element (fail_element),
        .err_count    (err_count)
    );

    // Backgrounds; bit 0 is 0 for patterns 0,3,5,6 and 1 for 1,2,4,7.
    function automatic logic [18:0] bg(input logic [2:0] p);
        case (p)
            3'd0: bg = 19'h00000;
            3'd1: bg = 19'h7FFFF;
            3'd2: bg = 19'h55555;
            3'd3: bg = 19'h2AAAA;
            3'd4: bg = 19'h33333;
            3'd5: bg = 19'h4CCCC;
            3'd6: bg = 19'h0F0F0;
            default: bg = 19'h70F0F;
        endcase
    endfunction

    function automatic logic [2:0] map_addr(input logic [2:0] a);
        map_addr = (fault_mode == 2 && a == 3'd3) ? 3'd2 : a;
    endfunction

    assign bus.MBIST_data = bg(bus.pattern_sel);

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        bus.mem_rdata = '0;
    end

    always @(posedge clk) begin
        logic [18:0] rv;
        if (bus.mem_wr_en) mem[map_addr(bus.mem_addr)] <= bus.mem_wdata;
        if (bus.mem_rd_en) begin
            rv = mem[map_addr(bus.mem_addr)];
            if (fault_mode == 1 && bus.mem_addr == 3'd5) rv[0] = 1'b1;
            bus.mem_rdata <= rv;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the falling edge inside op cycle 1.
    task automatic start_test();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 1500) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int busy_n, done_n, done_cyc, excl_bad;

        // Reset state
        #23;
        chk("rst_busy",   {31'd0, busy}, 0);
        chk("rst_done",   {31'd0, done}, 0);
        chk("rst_fail",   {31'd0, fail}, 0);
        chk("rst_err",    {24'd0, err_count}, 0);
        chk("rst_strobe", {30'd0, bus.mem_wr_en, bus.mem_rd_en}, 0);
        chk("rst_bus",    {10'd0, bus.pattern_sel, bus.mem_addr, bus.mem_wdata}, 0);
        chk("rst_diag",   {23'd0, fail_addr, fail_pattern, fail_element}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Fault-free full run with op trace
        fault_mode = 0;
        start_test();
        busy_n = 0; done_n = 0; done_cyc = 0; excl_bad = 0;
        for (int cyc = 1; cyc <= 660; cyc++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (bus.mem_wr_en && bus.mem_rd_en) excl_bad++;
            if (cyc == 1) begin
                chk("c1_busy", {31'd0, busy}, 1);
                chk("c1_op", {8'd0, bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}, {8'd0, 2'b10, 3'd0, 19'h00000});
            end
            if (cyc == 8)  chk("c8_op",  {8'd0, bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}, {8'd0, 2'b10, 3'd7, 19'h00000});
            if (cyc == 9)  chk("c9_op",  {8'd0, bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}, {8'd0, 2'b01, 3'd0, 19'h00000});
            if (cyc == 10) chk("c10_op", {8'd0, bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}, {8'd0, 2'b10, 3'd0, 19'h7FFFF});
            if (cyc == 41) chk("c41_e3", {8'd0, bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}, {8'd0, 2'b01, 3'd7, 19'h00000});
            if (cyc == 81) begin
                chk("c81_pat", {29'd0, bus.pattern_sel}, 1);
                chk("c81_op", {8'd0, bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}, {8'd0, 2'b10, 3'd0, 19'h7FFFF});
            end
            if (cyc == 641) chk("c641_drain_idle_bus", {30'd0, bus.mem_wr_en, bus.mem_rd_en}, 0);
            @(negedge clk);
        end
        chk("ff_busy_cycles", busy_n, 641);
        chk("ff_done_count",  done_n, 1);
        chk("ff_done_cycle",  done_cyc, 642);
        chk("ff_excl",        excl_bad, 0);
        chk("ff_fail",        {31'd0, fail}, 0);
        chk("ff_err",         {24'd0, err_count}, 0);

        // Stuck-at-1, bit 0, addr 5: 4 backgrounds x 3 + 4 x 2 = 20 expected-0 reads
        fault_mode = 1;
        start_test();
        wait_done("sa1");
        chk("sa1_fail", {31'd0, fail}, 1);
        chk("sa1_addr", {29'd0, fail_addr}, 5);
        chk("sa1_pat",  {29'd0, fail_pattern}, 0);
        chk("sa1_elem", {29'd0, fail_element}, 1);
        chk("sa1_err",  {24'd0, err_count}, 20);

        // Addr 3 aliases addr 2: E1 writes ~D to addr 2, then r0@3 reads it
        fault_mode = 2;
        start_test();
        wait_done("alias");
        chk("alias_fail", {31'd0, fail}, 1);
        chk("alias_addr", {29'd0, fail_addr}, 3);
        chk("alias_pat",  {29'd0, fail_pattern}, 0);
        chk("alias_elem", {29'd0, fail_element}, 1);
        chk("alias_err_nz", {31'd0, (err_count != 8'd0)}, 1);

        // Abort at cycle 100 with stuck-at fault: errors at reads in cycles 19, 45, 78
        fault_mode = 1;
        start_test();
        repeat (99) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("abort_busy",   {31'd0, busy}, 0);
        chk("abort_strobe", {30'd0, bus.mem_wr_en, bus.mem_rd_en}, 0);
        chk("abort_fail",   {31'd0, fail}, 1);
        chk("abort_err",    {24'd0, err_count}, 3);
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) done_n++;
            @(negedge clk);
        end
        chk("abort_no_done", done_n, 0);
        fault_mode = 0;
        start_test();
        chk("restart_fail", {31'd0, fail}, 0);
        chk("restart_err",  {24'd0, err_count}, 0);
        wait_done("restart");
        chk("restart_end_fail", {31'd0, fail}, 0);

        // Asynchronous reset mid-run
        fault_mode = 1;
        start_test();
        repeat (89) @(negedge clk);
        chk("prerst_fail", {31'd0, fail}, 1);
        chk("prerst_pat",  {29'd0, bus.pattern_sel}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",   {31'd0, busy}, 0);
        chk("arst_fail",   {31'd0, fail}, 0);
        chk("arst_err",    {24'd0, err_count}, 0);
        chk("arst_bus",    {8'd0, bus.mem_wr_en, bus.mem_rd_en, bus.pattern_sel, bus.mem_addr, bus.mem_wdata}, 0);
        @(negedge clk) rst_n = 1'b1;
        fault_mode = 0;
        start_test();
        wait_done("rerun");
        chk("rerun_fail", {31'd0, fail}, 0);
        chk("rerun_err",  {24'd0, err_count}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
